// File: rtl/noc_pkg.sv
// Shared constants and state encoding for the packet round-robin arbiter.
package noc_pkg;
  localparam int NREQ_MAX   = 4;
  localparam int FLIT_CNT_W = 4;
  localparam int TIMER_W    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first unmasked set request scanning
// from ptr upward, wrapping at N.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic [1:0]   ptr,
  output logic         found,
  output logic [1:0]   idx
);

  logic [2:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = 2'd0;
    pos   = 3'd0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + 3'(k);
      if (pos >= 3'(N)) pos = pos - 3'(N);
      if (!found && req[pos[1:0]] && !mask[pos[1:0]]) begin
        found = 1'b1;
        idx   = pos[1:0];
      end
    end
  end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-aware round-robin arbiter: holds a grant for PKT_LEN words, rotates
// priority on release, and force-releases an owner stalled for TIMEOUT cycles.
module pkt_rr_arbiter
  import noc_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int PKT_LEN = 4,
  parameter int TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            xfer,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      gnt_id,
  output logic            busy,
  output logic [3:0]      flit_cnt,
  output logic            abort,
  output logic            xfer_err,
  output logic            state_dbg
);

  // Handshake: a word moves when xfer=1 while busy; gnt is registered and
  // only changes at a release edge, never combinationally from req.

  arb_state_t           state_q, state_d;
  logic [NREQ-1:0]      gnt_d;
  logic [1:0]           gnt_id_d;
  logic [FLIT_CNT_W-1:0] flit_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [1:0]           ptr_q, ptr_d;
  logic                 abort_d, xerr_d;
  logic                 done;

  logic                 own_req;
  logic [1:0]           next_id;
  logic [NREQ-1:0]      pick_mask;
  logic [1:0]           pick_ptr;
  logic                 pick_found;
  logic [1:0]           pick_idx;

  assign own_req   = req[gnt_id];
  assign next_id   = (gnt_id == 2'(NREQ-1)) ? 2'd0 : gnt_id + 2'd1;
  // During OWN the picker serves the release path: current owner excluded,
  // scanning from the rotated pointer.
  assign pick_mask = (state_q == OWN) ? (NREQ'(1) << gnt_id) : '0;
  assign pick_ptr  = (state_q == OWN) ? next_id : ptr_q;

  rr_pick #(.N(NREQ)) u_pick (
    .req   (req),
    .mask  (pick_mask),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt;
    gnt_id_d = gnt_id;
    flit_d   = flit_cnt;
    timer_d  = timer_q;
    ptr_d    = ptr_q;
    abort_d  = 1'b0;
    xerr_d   = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        xerr_d = xfer;
        if (pick_found) begin
          state_d  = OWN;
          gnt_d    = NREQ'(1) << pick_idx;
          gnt_id_d = pick_idx;
          flit_d   = '0;
          timer_d  = '0;
        end
      end
      OWN: begin
        if (xfer) begin
          timer_d = '0;
          if (flit_cnt == FLIT_CNT_W'(PKT_LEN-1)) done = 1'b1;
          else flit_d = flit_cnt + 4'd1;
        end else if (own_req) begin
          timer_d = '0;
        end else begin
          timer_d = timer_q + 8'd1;
          if (timer_q == TIMER_W'(TIMEOUT-1)) begin
            done    = 1'b1;
            abort_d = 1'b1;
          end
        end

        if (done) begin
          ptr_d   = next_id;
          flit_d  = '0;
          timer_d = '0;
          if (pick_found) begin
            gnt_d    = NREQ'(1) << pick_idx;
            gnt_id_d = pick_idx;
          end else begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = 2'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gnt      <= '0;
      gnt_id   <= 2'd0;
      flit_cnt <= '0;
      timer_q  <= '0;
      ptr_q    <= 2'd0;
      abort    <= 1'b0;
      xfer_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt      <= gnt_d;
      gnt_id   <= gnt_id_d;
      flit_cnt <= flit_d;
      timer_q  <= timer_d;
      ptr_q    <= ptr_d;
      abort    <= abort_d;
      xfer_err <= xerr_d;
    end
  end

  assign busy      = (state_q == OWN);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Scoreboard bench for pkt_rr_arbiter: stimulus pushes predicted outputs from
// a packet-level model, a monitor pops and compares one entry per cycle.
module tb_pkt_rr_arbiter;
  localparam int NREQ    = 4;
  localparam int PKT_LEN = 4;
  localparam int TIMEOUT = 8;
  localparam int EW      = 14;

  logic            clk;
  logic            reset;
  logic [NREQ-1:0] req;
  logic            xfer;
  logic [NREQ-1:0] gnt;
  logic [1:0]      gnt_id;
  logic            busy;
  logic [3:0]      flit_cnt;
  logic            abort;
  logic            xfer_err;
  logic            state_dbg;

  pkt_rr_arbiter #(.NREQ(NREQ), .PKT_LEN(PKT_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .xfer      (xfer),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .flit_cnt  (flit_cnt),
    .abort     (abort),
    .xfer_err  (xfer_err),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  // packet-level reference: owner index (-1 = nobody), words in packet,
  // cycles stalled, priority start, and pulses produced this step
  int owner = -1;
  int words = 0;
  int stall = 0;
  int prio  = 0;
  int m_abort = 0;
  int m_xerr  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int start, input int excl);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (start + k) % NREQ;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  function automatic logic [EW-1:0] expected();
    logic [3:0] g;
    logic [1:0] id;
    g  = (owner >= 0) ? 4'(1 << owner) : 4'd0;
    id = (owner >= 0) ? 2'(owner) : 2'd0;
    return {g, id, (owner >= 0), 4'(words), 1'(m_abort), 1'(m_xerr), (owner >= 0)};
  endfunction

  task automatic model_reset();
    owner = -1; words = 0; stall = 0; prio = 0; m_abort = 0; m_xerr = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic x);
    bit rel;
    int w;
    m_abort = 0;
    m_xerr  = 0;
    rel     = 0;
    if (owner < 0) begin
      m_xerr = x;
      w = pick(r, prio, -1);
      if (w >= 0) begin owner = w; words = 0; stall = 0; end
    end else begin
      if (x) begin
        stall = 0;
        if (words + 1 == PKT_LEN) rel = 1;
        else words++;
      end else if (r[owner]) begin
        stall = 0;
      end else begin
        stall++;
        if (stall == TIMEOUT) begin rel = 1; m_abort = 1; end
      end
      if (rel) begin
        prio  = (owner + 1) % NREQ;
        w     = pick(r, prio, owner);
        owner = w;
        words = 0;
        stall = 0;
      end
    end
  endtask

  // driver tasks
  task automatic step(input logic [3:0] r, input logic x);
    @(negedge clk);
    reset = 1'b1;
    req   = r;
    xfer  = x;
    model_step(r, x);
    exp_q.push_back(expected());
  endtask

  task automatic step_rst();
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    xfer  = 1'b0;
    model_reset();
    exp_q.push_back(expected());
  endtask

  task automatic steps(input logic [3:0] r, input logic x, input int n);
    for (int i = 0; i < n; i++) step(r, x);
  endtask

  // monitor / scoreboard
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt",       32'(gnt),       32'(e[13:10]));
        chk("gnt_id",    32'(gnt_id),    32'(e[9:8]));
        chk("busy",      32'(busy),      32'(e[7]));
        chk("flit_cnt",  32'(flit_cnt),  32'(e[6:3]));
        chk("abort",     32'(abort),     32'(e[2]));
        chk("xfer_err",  32'(xfer_err),  32'(e[1]));
        chk("state",     32'(state_dbg), 32'(e[0]));
        chk("busy_vs_gnt", 32'(busy), 32'(|gnt));
      end
    end
  end

  initial begin
    int seg_len;
    int xp;
    int rp;
    logic [3:0] r;
    reset = 1'b0;
    req   = '0;
    xfer  = 1'b0;
    step_rst();
    step_rst();

    // single requester, packet of PKT_LEN words then idle
    steps(4'b0001, 1'b1, 7);
    steps(4'b0000, 1'b0, 2);

    // all requesting: rotation with back-to-back packets
    steps(4'b1111, 1'b1, 20);
    // everybody drops: owner times out into idle
    steps(4'b0000, 1'b0, 12);

    // owner 2 stalls after one word while 0 waits: abort hands over to 0
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    steps(4'b0001, 1'b0, 10);

    // owner 0 drops req for 3 cycles then finishes without abort
    step(4'b0001, 1'b1);
    steps(4'b0000, 1'b0, 3);
    steps(4'b0001, 1'b1, 3);
    steps(4'b0000, 1'b0, 2);

    // xfer while idle
    steps(4'b0000, 1'b1, 2);
    step(4'b0000, 1'b0);

    // async reset mid-packet, owner 1 with two words done
    step(4'b0010, 1'b0);
    steps(4'b0010, 1'b1, 2);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_gnt",      32'(gnt),      32'd0);
    chk("rst_gnt_id",   32'(gnt_id),   32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_flit_cnt", 32'(flit_cnt), 32'd0);
    chk("rst_abort",    32'(abort),    32'd0);
    chk("rst_xfer_err", 32'(xfer_err), 32'd0);
    model_reset();
    step_rst();
    step_rst();
    steps(4'b0011, 1'b0, 2);
    steps(4'b0011, 1'b1, 4);

    // randomized segments with varying request density and xfer rate
    for (int s = 0; s < 30; s++) begin
      seg_len = $urandom_range(5, 25);
      xp = $urandom_range(0, 4);
      rp = $urandom_range(0, 3);
      for (int i = 0; i < seg_len; i++) begin
        r = 4'($urandom_range(0, 15));
        if (rp == 0) r = 4'b0000;
        else if (rp == 1) r = r & 4'($urandom_range(0, 15));
        step(r, ($urandom_range(0, 3) < xp) ? 1'b1 : 1'b0);
      end
    end
    steps(4'b0000, 1'b0, 12);

    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pkt_rr_arbiter.md
Name: pkt_rr_arbiter

Overview:
- Packet-aware round-robin arbiter for one router output buffer, shared by up to NREQ input buffers.
- It keeps a grant on one requester for a whole packet of PKT_LEN word transfers, then rotates priority to the next requester.
- It releases a stalled owner after a timeout.
- The routing logic drives req/xfer, and uses gnt to steer the output mux and qualify in_get/out_put.

Parameters:
NREQ, 4, number of requesters (2..4)
PKT_LEN, 4, word transfers per packet before the grant is released (1..16; 1 = per-word arbitration)
TIMEOUT, 8, consecutive cycles with the owner's req low before a forced release (1..255)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
req  in  NREQ  request per input buffer (already qualified by emptybar/fullbar/valid)
xfer  in  1  one word moved to the output buffer this cycle (out_put)
gnt  out  NREQ  one-hot grant, registered
gnt_id  out  2  index of the current owner; 0 when idle
busy  out  1  a grant is held
flit_cnt  out  4  words transferred in the current packet
abort  out  1  one-cycle pulse on a timeout release
xfer_err  out  1  one-cycle pulse when xfer is seen while not busy

Behaviour:
- Reset (reset=0, async): gnt=0, gnt_id=0, busy=0, flit_cnt=0, abort=0, xfer_err=0, state=IDLE, priority pointer ptr=0, stall timer=0. Reset mid-packet discards the packet; no release pulse is generated.
- States: IDLE and OWN.
- IDLE:
  - If req!=0, pick the first set bit scanning ptr, ptr+1, ... modulo NREQ.
  - Next edge: gnt=onehot(winner), gnt_id=winner, busy=1, flit_cnt=0, state=OWN.
  - Latency from req to gnt is 1 cycle. gnt is never combinational from req.
- OWN, word counting:
  - A cycle with xfer=1 and req[gnt_id]=1 counts one word.
  - If flit_cnt==PKT_LEN-1, the word is the last one: release at this edge.
  - Otherwise flit_cnt increments.
  - xfer=1 while req[gnt_id]=0 is still counted. The owner may drop req in the same cycle as its last word.
- Release (last word or timeout):
  - ptr = (gnt_id+1) mod NREQ.
  - At the same edge, arbitrate over req with other owner bits masked: excluding gnt_id, scanning from the new ptr.
  - If a winner exists, load it directly with flit_cnt=0: back-to-back packets with zero idle cycles.
  - Otherwise go to IDLE with gnt=0, busy=0.
  - The released owner cannot regain the grant at the release edge. It can compete from the next cycle.
- Stall timer (OWN only):
  - Increments each cycle req[gnt_id]=0 and xfer=0.
  - Clears whenever req[gnt_id]=1 or xfer=1.
  - On reaching TIMEOUT: release as above, abort=1 for one cycle.
- xfer while IDLE: ignored for counting; xfer_err=1 next cycle.
- Requests from non-owners during OWN are held off. gnt changes only at release.
- ptr wraps NREQ-1 -> 0.
- Bits req[NREQ..3] do not exist. gnt_id is always < NREQ.
- Invariants: gnt is one-hot or zero; busy == |gnt.

Decomposition:
- Shared package (noc_pkg): NREQ_MAX=4, FLIT_CNT_W=4, TIMER_W=8, state encodings IDLE/OWN.
- One sub-module: rr_pick.
  - Combinational; inputs req, mask, ptr; outputs found, idx.
  - Used for both IDLE and release arbitration.
- The top holds the FSM, counters and registers.

Test Plan:
1. Reset then req=4'b0001, xfer=1 each cycle, PKT_LEN=4 -> gnt=0001 on cycle 1; release after the 4th xfer; gnt=0 on the following cycle; ptr=1.
2. req=4'b1111 continuous, xfer=1 always -> owners rotate 0,1,2,3,0, each for exactly 4 xfer cycles, with no gnt=0 cycle between packets.
3. Owner 2 granted; req=4'b0100 drops to 0 after 1 word with xfer=0; req[0]=1 -> after 8 cycles abort pulses once and gnt=0001 at the same edge; flit_cnt=0.
4. Owner drops req for 3 cycles, then reasserts -> no abort, stall timer clears, packet completes normally after 4 total words.
5. xfer=1 with req=0 while idle -> xfer_err pulses 1 cycle, flit_cnt stays 0, gnt stays 0.
6. Assert reset=0 asynchronously mid-packet (flit_cnt=2, owner 1) -> all outputs 0 immediately; after release, req=4'b0011 grants requester 0 (ptr=0).
